// File: rtl/bitmask_onehot_accumulator_pkg.sv
// Shared definitions for the one-hot beat accumulator: state encoding and
// the zero word used to clear the accumulator.
package bitmask_onehot_accumulator_pkg;

  typedef enum logic {
    ACCUMULATE = 1'b0,
    HOLD       = 1'b1
  } state_t;

  // Cast down to the instance's WORD_WIDTH where it is used.
  localparam logic [63:0] ZERO_WORD = '0;

endpackage

// File: rtl/bitmask_onehot_accumulator_isolate.sv
// Keeps only the lowest set bit of a word (x & -x); all-zero in, all-zero out.
module Bitmask_Isolate_Rightmost_1_Bit
  import bitmask_onehot_accumulator_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] word,
  output logic [WORD_WIDTH-1:0] isolated
);

  logic [WORD_WIDTH-1:0] negated;

  assign negated  = ~word + WORD_WIDTH'(1);
  assign isolated = word & negated;

endmodule

// File: rtl/bitmask_onehot_accumulator.sv
// ORs a stream of one-hot beats into one bitmask per packet, flagging
// multi-hot and duplicate beats, and hands the word out over ready/valid.
module bitmask_onehot_accumulator
  import bitmask_onehot_accumulator_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_onehot,
  input  logic                  input_last,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_word,
  output logic                  output_error_multi,
  output logic                  output_error_dup,
  output state_t                state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; ready never depends on valid, and valid/data are held
  // by the sender until the transfer.

  localparam logic [WORD_WIDTH-1:0] ZERO = WORD_WIDTH'(ZERO_WORD);

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] acc_q;
  logic                  err_multi_q;
  logic                  err_dup_q;

  logic [WORD_WIDTH-1:0] lowest_bit;
  logic                  beat_multi;
  logic                  beat_dup;
  logic                  accept;
  logic                  release_word;

  Bitmask_Isolate_Rightmost_1_Bit #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_isolate (
    .word     (input_onehot),
    .isolated (lowest_bit)
  );

  assign beat_multi = (input_onehot != lowest_bit);
  // Duplicate check looks at the accumulator before this beat is ORed in.
  assign beat_dup   = ((acc_q & input_onehot) != ZERO);

  assign accept       = input_valid & input_ready;
  assign release_word = output_valid & output_ready;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ACCUMULATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    case (state_q)
      ACCUMULATE: begin
        input_ready = 1'b1;
        if (accept && input_last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        output_valid = 1'b1;
        if (release_word) begin
          state_d = ACCUMULATE;
        end
      end
      default: state_d = ACCUMULATE;
    endcase
  end

  // Accept and release are exclusive by state, so one priority chain suffices.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      acc_q       <= ZERO;
      err_multi_q <= 1'b0;
      err_dup_q   <= 1'b0;
    end else if (release_word) begin
      acc_q       <= ZERO;
      err_multi_q <= 1'b0;
      err_dup_q   <= 1'b0;
    end else if (accept) begin
      acc_q       <= acc_q | input_onehot;
      err_multi_q <= err_multi_q | beat_multi;
      err_dup_q   <= err_dup_q | beat_dup;
    end
  end

  assign output_word        = acc_q;
  assign output_error_multi = err_multi_q;
  assign output_error_dup   = err_dup_q;
  assign state_dbg          = state_q;

endmodule

// File: doc/bitmask_onehot_accumulator.md
# bitmask_onehot_accumulator

Collects a stream of one-hot words, for example grants or single-bit events, into one accumulated bitmask per packet. It is the gathering end of a per-bit serialization: one set bit arrives per beat, and a beat flagged `input_last` closes the word. The block sits downstream of priority-arbiter or bit-serializer logic and returns a whole bitmask over a ready/valid interface. It also flags malformed (multi-hot) and duplicate beats.

## Interface
- `WORD_WIDTH`, default 8: width of input beats and output word; must be ≥ 1.
- `clock`  in  1: sole clock, rising edge.
- `clear_n`  in  1: asynchronous, active-low reset.
- `input_valid`  in  1: input beat present.
- `input_ready`  out  1: block accepts a beat this cycle.
- `input_onehot`  in  WORD_WIDTH: beat data; expected one-hot or zero.
- `input_last`  in  1: final beat of the current word.
- `output_valid`  out  1: accumulated word available.
- `output_ready`  in  1: consumer takes the word.
- `output_word`  out  WORD_WIDTH: OR of all accepted beats of the word.
- `output_error_multi`  out  1: at least one accepted beat had more than one bit set.
- `output_error_dup`  out  1: at least one accepted beat set a bit already set in the accumulator.

## Operation
- There are two states.
  - ACCUMULATE: `input_ready`=1, `output_valid`=0.
  - HOLD: `input_ready`=0, `output_valid`=1.
- A beat is accepted when `input_valid` and `input_ready` are both high.
- On accept, the accumulator becomes `accumulator | input_onehot`.
- Multi-hot detection: the beat is multi-hot when `input_onehot != (input_onehot & -input_onehot)`, using two's-complement negation at WORD_WIDTH bits. A multi-hot beat sets sticky `err_multi`.
- Duplicate detection: `(accumulator & input_onehot) != 0` sets sticky `err_dup`. The check uses the accumulator value before the OR.
- A zero beat is legal. It adds no bits and sets no flag. A zero beat with `input_last` simply closes the word.
- A multi-hot beat is still ORed in; it is flagged, not dropped.
- An accepted beat with `input_last`=1 moves ACCUMULATE to HOLD. The word is the accumulator including that beat, and the flags include that beat's checks.
- HOLD to ACCUMULATE happens on `output_valid & output_ready`. In the same edge, the accumulator, `err_multi` and `err_dup` are cleared to 0.
- `output_word`, `output_error_multi` and `output_error_dup` are driven directly from registers. They are stable throughout HOLD.
- In ACCUMULATE they show the partial accumulation. Consumers must qualify them with `output_valid`.
- `clear_n` low, at any time including mid-word: state goes to ACCUMULATE and the accumulator and both flags go to 0. The partial word is discarded.

## Timing
- Reset values: `input_ready`=1 once `clear_n` is deasserted; `output_valid`=0; `output_word`=0; both error outputs 0.
- `input_ready` is combinational from state only. It never depends on `input_valid`.
- Latency: `output_valid` rises on the clock edge that accepts the last beat, so it is visible the cycle after that beat.
- Throughput: one beat per cycle within a word.
- Minimum one bubble between words: the cycle in which the output handshake completes has `input_ready`=0.
- A single-beat word (last on first beat) takes 2 cycles minimum: accept, then handshake.
- `output_ready` held low keeps HOLD indefinitely. The input is back-pressured and no beat is lost.
- If `input_valid` is asserted during HOLD, the beat is not accepted. Upstream must hold it.
- Simultaneous events cannot occur: output handshake and input accept are mutually exclusive by state.

## Structure
- Shared package:
  - the state encoding (`ACCUMULATE`=1'b0, `HOLD`=1'b1);
  - a localparam for the zero word.
- Sub-module: instantiate `Bitmask_Isolate_Rightmost_1_Bit` on `input_onehot`. The multi-hot check compares its output against the input.
- All remaining logic is inline: state register, accumulator register, two flag registers, and the comparison.

## Test plan
- W=8. Beats 0x01, 0x08, 0x80 (last) → one word 0x89, both errors 0; `output_valid` appears the cycle after the 0x80 accept.
- Beats 0x04, 0x04 (last) → word 0x04, `output_error_dup`=1, `output_error_multi`=0.
- Beat 0x06, then 0x01 (last) → word 0x07, `output_error_multi`=1; the next word 0x10 (last) has both errors 0.
- Single zero beat with last → word 0x00, `output_valid`=1, no errors.
- Hold `output_ready`=0 for 10 cycles with the next word's `input_valid` asserted → `input_ready`=0 throughout. After the handshake, the next word accumulates from 0.
- Assert `clear_n`=0 after beats 0x02, 0x20 → outputs 0 and `output_valid`=0. After release, beat 0x40 (last) gives word 0x40.
